hack_memmap: RTL and testbench
==============================

# hack_memmap

Parametrised data-memory subsystem for the Hack CPU: general RAM, screen buffer with an independent GPU read port, and a keyboard register that is now backed by a keycode FIFO. The block also adds a free-running tick timer. It sits between `hack_cpu` (data port) and the display/keyboard front-ends, replacing the flat `ram` block with a decoded, configurable memory map.

## Interface
- WIDTH, 16, data word width
- RAM_WORDS, 16384, general RAM size in words, placed at address 0
- SCREEN_BASE, 16'h4000, first screen address
- SCREEN_WORDS, 8192, screen buffer size in words (power of two)
- KBD_ADDR, 16'h6000, keyboard register address
- TICK_ADDR, 16'h6001, tick timer address
- KBD_DEPTH, 4, keycode FIFO depth (power of two, ≥2)
- TICK_DIV, 1, clock cycles per tick increment (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  CPU write enable
- addr  in  16  CPU word address
- data_wr  in  WIDTH  CPU write data
- data_rd  out  WIDTH  CPU read data, registered
- gpu_addr  in  $clog2(SCREEN_WORDS)  screen-relative GPU read address
- gpu_data  out  WIDTH  GPU read data, registered
- kbd_valid  in  1  keycode offered
- kbd_code  in  WIDTH  keycode, nonzero
- kbd_ready  out  1  FIFO can accept a keycode

## Operation
- Decode, per cycle:
  - RAM: addr < RAM_WORDS.
  - SCREEN: SCREEN_BASE ≤ addr < SCREEN_BASE+SCREEN_WORDS.
  - KBD: addr == KBD_ADDR.
  - TICK: addr == TICK_ADDR.
  - Anything else is unmapped.
- Regions must not overlap. This is checked by an elaboration-time assertion.
- RAM/SCREEN writes store data_wr when we=1. Unmapped writes are ignored.
- Reads:
  - Unmapped reads return 0.
  - KBD read returns the FIFO head, or 0 if the FIFO is empty.
  - TICK read returns the counter.
- Keyboard FIFO:
  - Push when kbd_valid && kbd_ready.
  - kbd_ready = !full.
  - Any CPU write to KBD (data ignored) pops the head. A pop while empty is a no-op.
  - Simultaneous push and pop when full: the pop frees a slot, but kbd_ready is still low that cycle, so no push occurs.
  - Simultaneous push and pop when non-full: both occur; count unchanged.
  - Pointers wrap modulo KBD_DEPTH.
- Tick timer:
  - A prescaler counts 0..TICK_DIV-1; the counter increments on prescaler wrap and wraps modulo 2^WIDTH.
  - A CPU write to TICK loads data_wr and clears the prescaler. The write has priority over the increment in the same cycle.
- Screen storage is dual-port: CPU read/write port plus GPU read-only port, indexed by gpu_addr. GPU reads never stall or block the CPU.

## Timing
- data_rd: registered. It reflects the addr presented in cycle N at the edge ending cycle N, i.e. it is valid during cycle N+1. This 1-cycle read latency is fixed.
- Read-during-write, same CPU address: data_rd returns the old contents.
- KBD read in the same cycle as a KBD pop returns the head before the pop.
- gpu_data: 1-cycle latency from gpu_addr. If the CPU writes the same screen word in the same cycle, gpu_data returns the old contents.
- kbd_ready: combinational from FIFO count. A push is visible at KBD on the next cycle.
- Reset (rst=0, asynchronous), and on any reset mid-operation:
  - data_rd=0, gpu_data=0, FIFO empty, kbd_ready=1, tick=0, prescaler=0.
  - RAM/screen contents are not reset.
  - Outputs take effect immediately on assertion. The first edge after deassertion operates normally.

## Test plan
- RAM/unmapped: write 16'h1234 to 0x0005, then read 0x0005.
  - The cycle after the read, data_rd=16'h1234.
  - Read 0x7000 → 0. A write to 0x7000 leaves all regions unchanged.
- Screen dual-port: CPU writes 16'hBEEF to 0x4010 while gpu_addr=16 in the same cycle.
  - gpu_data in that next cycle is the old value.
  - On the following cycle, gpu_data=16'hBEEF.
- Keyboard FIFO: push 0x41, 0x42, 0x43, 0x44 (KBD_DEPTH=4).
  - kbd_ready=0 after the 4th push; a 5th kbd_valid is dropped.
  - Read KBD → 0x41. Write KBD, read → 0x42. Drain to empty → reads 0.
  - A pop while empty leaves the FIFO unchanged.
- FIFO simultaneous push/pop at count 2:
  - Count stays 2 and order is preserved.
  - At full, a simultaneous pop+valid leaves count 3 and the offered code is not taken.
- Tick: TICK_DIV=4.
  - Counter reads 0,0,0,0,1 across successive cycles.
  - Write 16'hFFFF, then after 4 cycles it reads 0 (wrap).
  - A write coinciding with an increment loads the written value.
- Reset mid-operation: assert rst=0 with FIFO at count 3 and tick=100.
  - Immediately: kbd_ready=1, data_rd=0, gpu_data=0, KBD read after release → 0, TICK → 0.
  - RAM word written before reset still reads back its value.

Source files
------------

// File: rtl/hack_memmap.sv
// Decoded Hack data-memory map: RAM, dual-port screen buffer, keycode FIFO at KBD
// and a prescaled free-running tick counter, all behind one registered CPU read port.
module hack_memmap #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_BASE  = 16'h4000,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned KBD_ADDR     = 16'h6000,
  parameter int unsigned TICK_ADDR    = 16'h6001,
  parameter int unsigned KBD_DEPTH    = 4,
  parameter int unsigned TICK_DIV     = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            we_i,
  input  logic [15:0]                     addr_i,
  input  logic [WIDTH-1:0]                data_wr_i,
  output logic [WIDTH-1:0]                data_rd_o,
  input  logic [$clog2(SCREEN_WORDS)-1:0] gpu_addr_i,
  output logic [WIDTH-1:0]                gpu_data_o,
  input  logic                            kbd_valid_i,
  input  logic [WIDTH-1:0]                kbd_code_i,
  output logic                            kbd_ready_o
);

  localparam int unsigned RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned SCR_AW  = $clog2(SCREEN_WORDS);
  localparam int unsigned KBD_AW  = $clog2(KBD_DEPTH);
  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCR_END = SCREEN_BASE + SCREEN_WORDS;

  // RAM always starts at 0, so any screen base below its end is an overlap.
  localparam bit REGION_OVERLAP =
      (SCREEN_BASE < RAM_WORDS) ||
      (KBD_ADDR < RAM_WORDS) || (KBD_ADDR >= SCREEN_BASE && KBD_ADDR < SCR_END) ||
      (TICK_ADDR < RAM_WORDS) || (TICK_ADDR >= SCREEN_BASE && TICK_ADDR < SCR_END) ||
      (KBD_ADDR == TICK_ADDR);

  if (REGION_OVERLAP) begin : gOverlapCheck
    $error("hack_memmap: memory regions overlap");
  end

  logic [31:0]        addrExt;
  logic               isRam, isScr, isKbd, isTick;
  logic [RAM_AW-1:0]  ramIdx;
  logic [SCR_AW-1:0]  scrIdx;

  logic [WIDTH-1:0]   ramMem_q  [RAM_WORDS];
  logic [WIDTH-1:0]   scrMem_q  [SCREEN_WORDS];
  logic [WIDTH-1:0]   fifoMem_q [KBD_DEPTH];

  logic [KBD_AW-1:0]  wrPtr_q, rdPtr_q;
  logic [KBD_AW:0]    count_q;
  logic               fifoFull, fifoEmpty, push, pop;

  logic [WIDTH-1:0]   tick_q;
  logic [PRE_W-1:0]   presc_q;

  logic [WIDTH-1:0]   rdData_d;
  logic [WIDTH-1:0]   dataRd_q, gpuData_q;

  assign addrExt = {16'b0, addr_i};
  assign isRam   = addrExt < RAM_WORDS;
  assign isScr   = (addrExt >= SCREEN_BASE) && (addrExt < SCR_END);
  assign isKbd   = addrExt == KBD_ADDR;
  assign isTick  = addrExt == TICK_ADDR;
  assign ramIdx  = RAM_AW'(addr_i);
  assign scrIdx  = SCR_AW'(addrExt - SCREEN_BASE);

  assign fifoFull  = count_q == (KBD_AW+1)'(KBD_DEPTH);
  assign fifoEmpty = count_q == '0;
  assign push      = kbd_valid_i && !fifoFull;
  assign pop       = we_i && isKbd && !fifoEmpty;

  // Storage arrays carry no reset; their contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (we_i && isRam) ramMem_q[ramIdx] <= data_wr_i;
    if (we_i && isScr) scrMem_q[scrIdx] <= data_wr_i;
    if (push)          fifoMem_q[wrPtr_q] <= kbd_code_i;
  end

  always_comb begin
    rdData_d = '0;
    if (isRam)       rdData_d = ramMem_q[ramIdx];
    else if (isScr)  rdData_d = scrMem_q[scrIdx];
    else if (isKbd)  rdData_d = fifoEmpty ? '0 : fifoMem_q[rdPtr_q];
    else if (isTick) rdData_d = tick_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dataRd_q  <= '0;
      gpuData_q <= '0;
    end else begin
      dataRd_q  <= rdData_d;
      gpuData_q <= scrMem_q[gpu_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + KBD_AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + KBD_AW'(1);
      if (push && !pop)      count_q <= count_q + (KBD_AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (KBD_AW+1)'(1);
    end
  end

  // A CPU load beats the prescaler wrap landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q  <= '0;
      presc_q <= '0;
    end else if (we_i && isTick) begin
      tick_q  <= data_wr_i;
      presc_q <= '0;
    end else if (presc_q == PRE_W'(TICK_DIV - 1)) begin
      presc_q <= '0;
      tick_q  <= tick_q + WIDTH'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  assign data_rd_o   = dataRd_q;
  assign gpu_data_o  = gpuData_q;
  assign kbd_ready_o = !fifoFull;

endmodule

// File: tb/tb_hack_memmap.sv
// Scoreboard bench for hack_memmap: directed scenarios plus random traffic,
// checked against a queue/array reference model of the memory map.
module tb_hack_memmap;

  localparam int unsigned SCREEN_BASE = 16'h4000;
  localparam int unsigned SCR_END     = 16'h6000;
  localparam int unsigned RAM_WORDS   = 16384;
  localparam int unsigned KBD_ADDR    = 16'h6000;
  localparam int unsigned TICK_ADDR   = 16'h6001;
  localparam int          KBD_DEPTH   = 4;
  localparam int          TICK_DIV    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h7000;
  logic [15:0] dataWr = 16'h0;
  logic [12:0] gpuAddr = 13'h0;
  logic        kbdValid = 1'b0;
  logic [15:0] kbdCode = 16'h0;
  logic [15:0] dataRd, gpuData;
  logic        kbdReady;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] mem [int];
  logic [15:0] kbdQ [$];
  logic [15:0] tickLoad = 16'h0;
  int          tickCycles = 0;

  // Scoreboard queues, one entry per driven clock cycle
  string       nameQ [$];
  logic [15:0] rdQ [$];
  bit          rdKnownQ [$];
  logic [15:0] gpuQ [$];
  bit          gpuKnownQ [$];
  bit          readyQ [$];

  hack_memmap #(
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (we),
    .addr_i     (addr),
    .data_wr_i  (dataWr),
    .data_rd_o  (dataRd),
    .gpu_addr_i (gpuAddr),
    .gpu_data_o (gpuData),
    .kbd_valid_i(kbdValid),
    .kbd_code_i (kbdCode),
    .kbd_ready_o(kbdReady)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tickNow();
    return tickLoad + 16'(tickCycles / TICK_DIV);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, push the expected response, advance the model.
  task automatic applyStimulus(input logic w, input logic [15:0] ad, input logic [15:0] d,
                               input logic [12:0] g, input logic kv, input logic [15:0] kc,
                               input string name);
    int unsigned a;
    int unsigned ga;
    logic [15:0] rd;
    bit          rdKnown;
    bit          readyBefore;
    @(negedge clk);
    we = w; addr = ad; dataWr = d; gpuAddr = g; kbdValid = kv; kbdCode = kc;
    a = int'(ad);
    rd = 16'h0;
    rdKnown = 1'b1;
    if (a < RAM_WORDS || (a >= SCREEN_BASE && a < SCR_END)) begin
      if (mem.exists(int'(a))) rd = mem[int'(a)];
      else rdKnown = 1'b0;
    end else if (a == KBD_ADDR) begin
      rd = (kbdQ.size() > 0) ? kbdQ[0] : 16'h0;
    end else if (a == TICK_ADDR) begin
      rd = tickNow();
    end
    ga = SCREEN_BASE + int'(g);
    nameQ.push_back(name);
    rdQ.push_back(rd);
    rdKnownQ.push_back(rdKnown);
    gpuKnownQ.push_back(mem.exists(int'(ga)));
    gpuQ.push_back(mem.exists(int'(ga)) ? mem[int'(ga)] : 16'h0);
    readyBefore = kbdQ.size() < KBD_DEPTH;
    if (w && (a < RAM_WORDS || (a >= SCREEN_BASE && a < SCR_END))) mem[int'(a)] = d;
    if (w && a == KBD_ADDR && kbdQ.size() > 0) void'(kbdQ.pop_front());
    if (kv && readyBefore) kbdQ.push_back(kc);
    if (w && a == TICK_ADDR) begin
      tickLoad = d;
      tickCycles = 0;
    end else begin
      tickCycles++;
    end
    readyQ.push_back(kbdQ.size() < KBD_DEPTH);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b0, 16'h0, "idle");
  endtask

  task automatic doReset(input string name);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({name, " data_rd"}, dataRd, 16'h0);
    checkOutput({name, " gpu_data"}, gpuData, 16'h0);
    checkOutput({name, " kbd_ready"}, {15'h0, kbdReady}, 16'h1);
    kbdQ.delete();
    tickLoad = 16'h0;
    tickCycles = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Monitor: compares every registered output right after each active edge.
  initial begin
    string       n;
    logic [15:0] r, g;
    bit          rk, gk, rdy;
    forever begin
      @(posedge clk);
      #1;
      if (nameQ.size() > 0) begin
        n = nameQ.pop_front();
        r = rdQ.pop_front();   rk = rdKnownQ.pop_front();
        g = gpuQ.pop_front();  gk = gpuKnownQ.pop_front();
        rdy = readyQ.pop_front();
        if (rk) checkOutput({n, " data_rd"}, dataRd, r);
        if (gk) checkOutput({n, " gpu_data"}, gpuData, g);
        checkOutput({n, " kbd_ready"}, {15'h0, kbdReady}, {15'h0, rdy});
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pool [16];
    logic [12:0] gpool [4];
    pool  = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h0007, 16'h3FFF, 16'h4000, 16'h4001,
              16'h4010, 16'h5FFF, 16'h6000, 16'h6000, 16'h6001, 16'h6002, 16'h7000, 16'hFFFF};
    gpool = '{13'd0, 13'd1, 13'd16, 13'd8191};

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset data_rd", dataRd, 16'h0);
    checkOutput("reset gpu_data", gpuData, 16'h0);
    checkOutput("reset kbd_ready", {15'h0, kbdReady}, 16'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // RAM and unmapped space
    applyStimulus(1'b1, 16'h0005, 16'h1234, 13'd0, 1'b0, 16'h0, "ram write");
    applyStimulus(1'b0, 16'h0005, 16'h0,    13'd0, 1'b0, 16'h0, "ram read");
    applyStimulus(1'b0, 16'h7000, 16'h0,    13'd0, 1'b0, 16'h0, "unmapped read");
    applyStimulus(1'b1, 16'h7000, 16'hDEAD, 13'd0, 1'b0, 16'h0, "unmapped write");
    applyStimulus(1'b0, 16'h7000, 16'h0,    13'd0, 1'b0, 16'h0, "unmapped reread");
    applyStimulus(1'b0, 16'h0005, 16'h0,    13'd0, 1'b0, 16'h0, "ram reread");

    // Screen dual port, CPU write and GPU read of the same word
    applyStimulus(1'b1, 16'h4010, 16'h1111, 13'd16, 1'b0, 16'h0, "screen preload");
    applyStimulus(1'b1, 16'h4010, 16'hBEEF, 13'd16, 1'b0, 16'h0, "screen rdw old");
    applyStimulus(1'b0, 16'h4010, 16'h0,    13'd16, 1'b0, 16'h0, "screen new");
    applyStimulus(1'b0, 16'h7000, 16'h0,    13'd16, 1'b0, 16'h0, "gpu hold");

    // Keyboard FIFO fill, overflow drop, pops and empty pop
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b1, 16'h0041 + 16'(i), "kbd push");
    applyStimulus(1'b0, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd head");
    applyStimulus(1'b1, 16'h6000, 16'h9999, 13'd0, 1'b0, 16'h0, "kbd pop read");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd drain");
    applyStimulus(1'b0, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd empty");
    applyStimulus(1'b1, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd empty pop");
    applyStimulus(1'b0, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd still empty");

    // Simultaneous push/pop at count 2, then at full
    applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b1, 16'h0051, "kbd push2");
    applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b1, 16'h0052, "kbd push2");
    applyStimulus(1'b1, 16'h6000, 16'h0, 13'd0, 1'b1, 16'h0053, "kbd pushpop");
    applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b1, 16'h0054, "kbd fill");
    applyStimulus(1'b0, 16'h7000, 16'h0, 13'd0, 1'b1, 16'h0055, "kbd fill");
    applyStimulus(1'b1, 16'h6000, 16'h0, 13'd0, 1'b1, 16'h0056, "kbd full pushpop");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'h6000, 16'h0, 13'd0, 1'b0, 16'h0, "kbd order");

    // Tick timer with prescaler of 4
    applyStimulus(1'b1, 16'h6001, 16'h0000, 13'd0, 1'b0, 16'h0, "tick load0");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h6001, 16'h0, 13'd0, 1'b0, 16'h0, "tick count");
    applyStimulus(1'b1, 16'h6001, 16'hFFFF, 13'd0, 1'b0, 16'h0, "tick loadFFFF");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h6001, 16'h0, 13'd0, 1'b0, 16'h0, "tick wrap");
    applyStimulus(1'b1, 16'h6001, 16'h0000, 13'd0, 1'b0, 16'h0, "tick reload");
    idle(3);
    applyStimulus(1'b1, 16'h6001, 16'h1234, 13'd0, 1'b0, 16'h0, "tick write vs inc");
    applyStimulus(1'b0, 16'h6001, 16'h0, 13'd0, 1'b0, 16'h0, "tick write wins");

    // Reset mid-operation with FIFO at 3 and tick at 100
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 16'h7000, 16'h0, 13'd16, 1'b1, 16'h0061 + 16'(i), "pre-reset push");
    applyStimulus(1'b1, 16'h6001, 16'd100, 13'd16, 1'b0, 16'h0, "pre-reset tick");
    applyStimulus(1'b0, 16'h6001, 16'h0, 13'd16, 1'b0, 16'h0, "pre-reset read");
    doReset("midreset");
    applyStimulus(1'b0, 16'h6001, 16'h0, 13'd16, 1'b0, 16'h0, "post-reset tick");
    applyStimulus(1'b0, 16'h6000, 16'h0, 13'd16, 1'b0, 16'h0, "post-reset kbd");
    applyStimulus(1'b0, 16'h0005, 16'h0, 13'd16, 1'b0, 16'h0, "post-reset ram");

    // Random traffic across every region
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 2) == 0, pool[$urandom_range(0, 15)], 16'($urandom),
                    gpool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                    16'($urandom_range(1, 65535)), "random");

    @(posedge clk);
    #3;
    checkOutput("scoreboard drained", 16'(nameQ.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
